decoder_rr_arbiter: RTL and testbench
=====================================

# decoder_rr_arbiter

Round-robin arbiter sharing one downstream resource among four requesters. Holds a registered 2-bit owner index and drives the one-hot grant through a `decoder_2to4` instance, so exactly one requester owns the resource at a time. Sits between the four requesting agents and the shared datapath; the decoder's enable acts as the grant-valid qualifier.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per owner when others are waiting. Used only with `ARB_TIMEOUT_EN`; legal range 2..255.
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req` input 4: request per agent; agent holds it high for as long as it needs the resource.
- `gnt` output 4: one-hot grant, or all-zero when idle; equals the decoder output.
- `gnt_valid` output 1: high in the GRANT state; drives the decoder enable.
- `gnt_id` output 2: current or last owner index.

## Operation
- States:
  - IDLE: no owner; `gnt_valid`=0 and `gnt`=0000.
  - GRANT: owner is `gnt_id`; `gnt_valid`=1 and `gnt`=1<<`gnt_id`.
- Selection: pick the first asserted `req` bit scanning `gnt_id`+1, +2, +3, +4, all mod 4. The last owner has the lowest priority.
- IDLE to GRANT: if any `req` is set, load the selected index into `gnt_id`. Otherwise stay in IDLE and hold `gnt_id`.
- In GRANT with `req[gnt_id]`=1: stay in GRANT with the same owner (subject to the timeout below).
- In GRANT with `req[gnt_id]`=0:
  - If another `req` bit is set, load the selected index and stay in GRANT. This is a direct handover with no idle cycle.
  - Otherwise go to IDLE.
- Requests are sampled every cycle. A requester dropping `req` while not granted is simply not selected.
- The owner dropping and re-raising `req` in one cycle is not visible; `req` is edge-free.
- All outputs are registered-state driven: `gnt` is a pure decode of registered `gnt_id` and state, with no combinational path from `req`.
- Reset values: state IDLE, `gnt_id`=3 (so the first scan starts at 0), `gnt`=0000, `gnt_valid`=0, hold counter 0.
- Reset mid-grant: `rst_n`=0 at a clock edge forces the reset values on that edge, regardless of `req`.

## Timing
- Grant latency: `req` high at edge N while IDLE gives `gnt` high after edge N, i.e. visible in cycle N+1.
- Release: owner `req` low sampled at edge M gives the new grant, or 0000, from cycle M+1. The old owner sees its `gnt` for exactly one cycle after dropping `req`.
- Simultaneous requests: at most one `gnt` bit is ever high. There are never two owners in the same cycle, including handover cycles.
- Fairness: with all four requests held and owners releasing after K cycles, grants rotate 0,1,2,3,0,...

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on every owner change and increments each GRANT cycle, saturating.
  - When the counter equals `MAX_HOLD`-1 and another request is pending, the owner is preempted: the next index is loaded as if the owner had released.
  - With no other request pending, the owner keeps the grant indefinitely.
- `ARB_TIMEOUT_EN` undefined: no counter, no `MAX_HOLD` use; an owner holds until it drops `req`.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ`=4, `ID_W`=2.
  - State enum (IDLE, GRANT).
  - Reset index constant `RST_ID`=2'd3.
- Sub-module: one `decoder_2to4` instance mapped `enable`=`gnt_valid`, `in`=`gnt_id`, `out`=`gnt`.
- Next-index selection is a combinational function in this module.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=1111 -> `gnt`=0000, `gnt_valid`=0, `gnt_id`=3. After release, `gnt`=0001 one cycle later.
- Single requester: `req`=0100 for 5 cycles then 0000 -> `gnt`=0100 from cycle 1 through cycle 5 (one cycle after the drop), then 0000 and IDLE.
- Round robin: `req`=1111 held, each owner drops its bit for one cycle after 3 cycles of grant -> owner sequence 0,1,2,3,0 with no 0000 cycle between owners.
- Priority after owner: last owner 1, `req`=0011 from IDLE -> `gnt`=0001 (scan 2,3,0 finds 0 first).
- Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4): `req`=1001 held constantly -> `gnt` alternates 0001 ×4 cycles, 1000 ×4, 0001 ×4. With `req`=0001 only, `gnt`=0001 persists beyond 4 cycles.
- Reset mid-grant: `rst_n`=0 for one edge while `gnt`=0010 -> next cycle `gnt`=0000, `gnt_id`=3. Arbitration then restarts from index 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin grant arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reset owner is the last index so the first scan starts at requester 0.
  localparam logic [ID_W-1:0] RST_ID = 2'd3;

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module decoder_2to4 (
  input  logic       enable,
  input  logic [1:0] in,
  output logic [3:0] out
);

  always_comb begin
    out = 4'b0000;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-way round-robin arbiter; grant is a decode of the registered owner index.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | no owner, gnt = 0000, gnt_id holds last owner
//   GRANT | gnt_id owns the resource, gnt = 1 << gnt_id
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("MAX_HOLD must be in 2..255");
  end

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_d;
  logic [ID_W-1:0]  sel;
  logic             owner_req;
  logic             others;

  // First asserted request scanning last+1 .. last+4; the last owner is scanned last.
  function automatic logic [ID_W-1:0] next_id(input logic [N_REQ-1:0] r,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] idx;
    logic            found;
    next_id = last;
    found   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + ID_W'(i);
      if (!found && r[idx]) begin
        next_id = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = gnt_id;
    sel       = next_id(req, gnt_id);
    owner_req = req[gnt_id];
    others    = |(req & ~(N_REQ'(1) << gnt_id));
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          id_d    = sel;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          if (others) id_d = sel;
          else        state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST && others) begin
          id_d = sel;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        id_d    = RST_ID;
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    // Counts consecutive cycles of the same owner; any owner change restarts it.
    hold_d = 8'd0;
    if (state_q == GRANT && state_d == GRANT && id_d == gnt_id)
      hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_id  <= RST_ID;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_id  <= id_d;
`ifdef ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign gnt_valid = (state_q == GRANT);

  decoder_2to4 u_decoder (
    .enable (gnt_valid),
    .in     (gnt_id),
    .out    (gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scoreboard bench for decoder_rr_arbiter: directed vectors with hand-computed results.
module tb_decoder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    int         vec;
  } exp_t;

  exp_t exp_q[$];
  int   vec_no = 0;

  decoder_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  // Apply one input vector and queue what must be visible after the next rising edge.
  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic ev, input logic [1:0] eid);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    e.gnt = eg; e.valid = ev; e.id = eid; e.vec = vec_no;
    exp_q.push_back(e);
    vec_no++;
  endtask

  // Monitor: compares DUT outputs after every edge that has a queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e.gnt || gnt_valid !== e.valid || gnt_id !== e.id) begin
          failures++;
          $display("FAIL vec%0d outputs: gnt=%b valid=%b id=%0d required gnt=%b valid=%b id=%0d",
                   e.vec, gnt, gnt_valid, gnt_id, e.gnt, e.valid, e.id);
        end
        checks++;
        if (!$onehot0(gnt)) begin
          failures++;
          $display("FAIL vec%0d onehot: gnt=%b required at most one bit", e.vec, gnt);
        end
      end
    end
  end

  initial begin
    // Reset with all requests pending, then release.
    step(0, 4'b1111, 4'b0000, 0, 2'd3);
    step(0, 4'b1111, 4'b0000, 0, 2'd3);
    step(1, 4'b1111, 4'b0001, 1, 2'd0);
    step(1, 4'b0000, 4'b0000, 0, 2'd0);

    // Single requester 2 for five cycles, then release to IDLE.
    for (int i = 0; i < 5; i++) step(1, 4'b0100, 4'b0100, 1, 2'd2);
    step(1, 4'b0000, 4'b0000, 0, 2'd2);
    step(1, 4'b0000, 4'b0000, 0, 2'd2);

    // Round robin with all requests held; each owner drops its bit once.
    step(0, 4'b0000, 4'b0000, 0, 2'd3);
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 4'b0001, 1, 2'd0);
    step(1, 4'b1110, 4'b0010, 1, 2'd1);
    for (int i = 0; i < 2; i++) step(1, 4'b1111, 4'b0010, 1, 2'd1);
    step(1, 4'b1101, 4'b0100, 1, 2'd2);
    for (int i = 0; i < 2; i++) step(1, 4'b1111, 4'b0100, 1, 2'd2);
    step(1, 4'b1011, 4'b1000, 1, 2'd3);
    for (int i = 0; i < 2; i++) step(1, 4'b1111, 4'b1000, 1, 2'd3);
    step(1, 4'b0111, 4'b0001, 1, 2'd0);
    step(1, 4'b0000, 4'b0000, 0, 2'd0);

    // Priority after owner 1: scan 2,3,0 picks 0.
    step(1, 4'b0010, 4'b0010, 1, 2'd1);
    step(1, 4'b0000, 4'b0000, 0, 2'd1);
    step(1, 4'b0011, 4'b0001, 1, 2'd0);
    step(1, 4'b0011, 4'b0001, 1, 2'd0);
    step(1, 4'b0010, 4'b0010, 1, 2'd1);
    step(1, 4'b0000, 4'b0000, 0, 2'd1);

    // Two requesters held constantly, then a lone requester.
    step(0, 4'b0000, 4'b0000, 0, 2'd3);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) step(1, 4'b1001, 4'b0001, 1, 2'd0);
    for (int i = 0; i < 4; i++) step(1, 4'b1001, 4'b1000, 1, 2'd3);
    for (int i = 0; i < 4; i++) step(1, 4'b1001, 4'b0001, 1, 2'd0);
`else
    for (int i = 0; i < 12; i++) step(1, 4'b1001, 4'b0001, 1, 2'd0);
`endif
    for (int i = 0; i < 6; i++) step(1, 4'b0001, 4'b0001, 1, 2'd0);
    step(1, 4'b0000, 4'b0000, 0, 2'd0);

    // Reset while requester 1 owns the resource; arbitration restarts at 0.
    step(1, 4'b0010, 4'b0010, 1, 2'd1);
    step(0, 4'b0010, 4'b0000, 0, 2'd3);
    step(1, 4'b1111, 4'b0001, 1, 2'd0);
    step(1, 4'b0000, 4'b0000, 0, 2'd0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
